// File: rtl/btn_debounce_if.sv
// Signal bundle between a raw button source and the debounce/synchroniser block.
// The source side (master) drives btn_in; the debouncer (slave) drives the conditioned outputs.
interface btn_debounce_if;
  logic btn_in;
  logic db_out;
  logic db_out_n;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  db_out, db_out_n, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  btn_in,
    output db_out, db_out_n, rise_pulse, fall_pulse, busy
  );
endinterface

// File: rtl/btn_debounce_sync.sv
// Two-flop synchroniser followed by a stable-count debounce FSM.
// Produces a clean level plus single-cycle rise/fall pulses.
module btn_debounce_sync #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  btn_debounce_if.slave   bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic             sync_p0, sync_p1;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             db_q, db_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;
  logic             busy_q, busy_nxt;

  // Stage p0/p1: synchroniser into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE_LOW;
      cnt    <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      db_q   <= db_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      busy_q <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = db_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync_p1) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_p1) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          db_nxt    = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_p1) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_p1) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          db_nxt    = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
    // busy is registered, so it reflects the state being entered
    busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

  assign bus.db_out     = db_q;
  assign bus.db_out_n   = ~db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Directed bench for btn_debounce_sync with STABLE_CYCLES=4.
// Output vector order everywhere: {db_out, db_out_n, rise_pulse, fall_pulse, busy}.
module tb_btn_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  btn_debounce_if bus ();

  btn_debounce_sync #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] outs();
    return {bus.db_out, bus.db_out_n, bus.rise_pulse, bus.fall_pulse, bus.busy};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (db,db_n,rise,fall,busy) at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic btn, input logic db, input logic rise,
                     input logic fall, input logic busy);
    vec_t v;
    v.name = name;
    v.btn  = btn;
    v.exp  = {db, ~db, rise, fall, busy};
    vecs.push_back(v);
  endtask

  // Clean press then release from idle-low; busy over edges 2..4, change at edge 5.
  task automatic add_press(input string tag);
    add({tag, "_e0"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add({tag, "_e1"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add({tag, "_e2"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add({tag, "_e3"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add({tag, "_e4"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add({tag, "_e5"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add({tag, "_e6"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_release(input string tag);
    add({tag, "_e0"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add({tag, "_e1"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add({tag, "_e2"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add({tag, "_e3"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add({tag, "_e4"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add({tag, "_e5"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add({tag, "_e6"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] o;
    int         rises;

    bus.btn_in = 1'b0;

    // idle
    add("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_press("press");
    add_release("rel1");
    // glitch: two cycles high while db_out=0
    add("glitch_e0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("glitch_e1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("glitch_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("glitch_e3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("glitch_e4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("glitch_e5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // bounce 1,0,1,1,0 then held high; rise 5 edges after the last 0->1 (edge 5)
    add("bounce_e0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("bounce_e1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("bounce_e2",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_e3",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("bounce_e4",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_e5",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_e6",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("bounce_e7",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_e8",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_e9",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add("bounce_e10", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add("bounce_e11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_release("rel2");

    // power-on reset held across edges
    repeat (2) @(posedge clk);
    #1;
    check("por", outs(), 5'b01000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_in = vecs[i].btn;
      @(posedge clk);
      #1;
      o = outs();
      check(vecs[i].name, o, vecs[i].exp);
      checks++;
      if (o[2] && o[1 + 0] && o[2] == o[1]) begin end
      if (bus.rise_pulse && bus.fall_pulse) begin
        errors++;
        $display("FAIL pulse_excl_%s: rise=%b fall=%b required not both 1", vecs[i].name,
                 bus.rise_pulse, bus.fall_pulse);
      end
    end

    // reset during WAIT_HIGH with cnt=2, then a full re-acceptance
    bus.btn_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    check("wait_before_rst", outs(), 5'b01001);
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_wait_async", outs(), 5'b01000);
    @(posedge clk);
    #1;
    check("rst_in_wait_held", outs(), 5'b01000);
    rst = 1'b0;
    rises = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      o = outs();
      if (o[2]) rises++;
      check($sformatf("post_rst_e%0d", k), o,
            {(k >= 6), (k < 6), (k == 6), 1'b0, (k >= 3 && k <= 5)});
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL post_rst_rise_count: got %0d expected 1", rises);
    end

    // asynchronous reset mid-cycle while db_out=1 and btn_in=1
    check("pre_async_rst", outs(), 5'b10000);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_now", outs(), 5'b01000);
    @(posedge clk);
    #1;
    check("async_rst_held", outs(), 5'b01000);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
